// File: rtl/ex_top.sv
// Execute stage of the multicycle RV32I core.
// Single-cycle ALU/compare/target evaluation, plus an iterative shifter
// that retires SHIFT_STEP bit positions per busy cycle.
// Control pass-through layouts:
//   i_ctrlMEM = {branch, jump, mem_read, mem_write}
//   i_ctrlWB  = {reg_write, mem_to_reg}
module ex_top #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        en_EX,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1Data,
  input  logic [31:0] i_rs2Data,
  input  logic [31:0] i_imm,
  input  logic [3:0]  i_aluOp,
  input  logic        i_aluSrcA,
  input  logic        i_aluSrcB,
  input  logic [2:0]  i_brFunct3,
  input  logic        i_isJalr,
  input  logic [3:0]  i_ctrlMEM,
  input  logic [1:0]  i_ctrlWB,
  output logic [31:0] o_aluResult,
  output logic [31:0] o_wrData,
  output logic        o_zero,
  output logic [31:0] o_branchTarget,
  output logic [31:0] o_linkAddr,
  output logic [3:0]  o_ctrlMEM,
  output logic [1:0]  o_ctrlWB,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  localparam logic [4:0] STEP_AMT = 5'(SHIFT_STEP);
  localparam logic [1:0] SK_SLL = 2'd0;
  localparam logic [1:0] SK_SRL = 2'd1;
  localparam logic [1:0] SK_SRA = 2'd2;

  state_t      state_r, state_nxt;
  logic [31:0] a_s, b_s, alu_s, target_s, link_s;
  logic [4:0]  shamt_s;
  logic        is_shift_s, zero_s;
  logic [1:0]  kind_s, kind_r;
  logic [31:0] work_r, work_nxt, shifted_s;
  logic [4:0]  rem_r, rem_nxt, step_s;
  logic        start_shift_s, commit_idle_s, commit_shift_s;
  // Captured side-band results of an instruction parked in the shifter
  logic [31:0] pend_wr_r, pend_tgt_r, pend_link_r;
  logic        pend_zero_r;
  logic [3:0]  pend_mem_r;
  logic [1:0]  pend_wb_r;
  // Registered output copies
  logic [31:0] res_r, wr_r, tgt_r, link_r;
  logic        zero_r, busy_r, done_r;
  logic [3:0]  mem_r;
  logic [1:0]  wb_r;

  // Operand selection and single-cycle ALU; shift ops yield A for the shamt=0 case
  always_comb begin
    a_s        = i_aluSrcA ? i_pc : i_rs1Data;
    b_s        = i_aluSrcB ? i_imm : i_rs2Data;
    shamt_s    = b_s[4:0];
    is_shift_s = 1'b0;
    kind_s     = SK_SLL;
    alu_s      = 32'd0;
    case (i_aluOp)
      4'd0:    alu_s = a_s + b_s;
      4'd1:    alu_s = a_s - b_s;
      4'd2:    begin is_shift_s = 1'b1; kind_s = SK_SLL; alu_s = a_s; end
      4'd3:    alu_s = {31'd0, ($signed(a_s) < $signed(b_s))};
      4'd4:    alu_s = {31'd0, (a_s < b_s)};
      4'd5:    alu_s = a_s ^ b_s;
      4'd6:    begin is_shift_s = 1'b1; kind_s = SK_SRL; alu_s = a_s; end
      4'd7:    begin is_shift_s = 1'b1; kind_s = SK_SRA; alu_s = a_s; end
      4'd8:    alu_s = a_s | b_s;
      4'd9:    alu_s = a_s & b_s;
      4'd10:   alu_s = b_s;
      default: alu_s = 32'd0;
    endcase
  end

  // Branch condition (always rs1 vs rs2), jump/branch target and link address
  always_comb begin
    zero_s = 1'b0;
    case (i_brFunct3)
      3'b000:  zero_s = (i_rs1Data == i_rs2Data);
      3'b001:  zero_s = (i_rs1Data != i_rs2Data);
      3'b100:  zero_s = ($signed(i_rs1Data) <  $signed(i_rs2Data));
      3'b101:  zero_s = ($signed(i_rs1Data) >= $signed(i_rs2Data));
      3'b110:  zero_s = (i_rs1Data <  i_rs2Data);
      3'b111:  zero_s = (i_rs1Data >= i_rs2Data);
      default: zero_s = 1'b0;
    endcase
    if (i_isJalr) begin
      target_s = (i_rs1Data + i_imm) & 32'hFFFF_FFFE;
    end else begin
      target_s = i_pc + i_imm;
    end
    link_s = i_pc + 32'd4;
  end

  // One shifter step: move work by min(SHIFT_STEP, rem) positions
  always_comb begin
    step_s = (rem_r < STEP_AMT) ? rem_r : STEP_AMT;
    case (kind_r)
      SK_SLL:  shifted_s = work_r << step_s;
      SK_SRL:  shifted_s = work_r >> step_s;
      SK_SRA:  shifted_s = $unsigned($signed(work_r) >>> step_s);
      default: shifted_s = work_r;
    endcase
  end

  // Next-state logic and commit/start strobes
  always_comb begin
    state_nxt      = state_r;
    work_nxt       = work_r;
    rem_nxt        = rem_r;
    start_shift_s  = 1'b0;
    commit_idle_s  = 1'b0;
    commit_shift_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en_EX) begin
          if (is_shift_s && (shamt_s != 5'd0)) begin
            state_nxt     = ST_SHIFT;
            start_shift_s = 1'b1;
            work_nxt      = a_s;
            rem_nxt       = shamt_s;
          end else begin
            commit_idle_s = 1'b1;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_nxt = shifted_s;
        rem_nxt  = rem_r - step_s;
        if (rem_nxt == 5'd0) begin
          commit_shift_s = 1'b1;
          state_nxt      = ST_IDLE;
        end else begin
          state_nxt = ST_SHIFT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Shifter working registers and capture of side-band results at shift start
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      work_r      <= 32'd0;
      rem_r       <= 5'd0;
      kind_r      <= SK_SLL;
      pend_wr_r   <= 32'd0;
      pend_tgt_r  <= 32'd0;
      pend_link_r <= 32'd0;
      pend_zero_r <= 1'b0;
      pend_mem_r  <= 4'd0;
      pend_wb_r   <= 2'd0;
    end else begin
      work_r <= work_nxt;
      rem_r  <= rem_nxt;
      if (start_shift_s) begin
        kind_r      <= kind_s;
        pend_wr_r   <= i_rs2Data;
        pend_tgt_r  <= target_s;
        pend_link_r <= link_s;
        pend_zero_r <= zero_s;
        pend_mem_r  <= i_ctrlMEM;
        pend_wb_r   <= i_ctrlWB;
      end
    end
  end

  // Output registers: update only on commit, hold otherwise
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      res_r  <= 32'd0;
      wr_r   <= 32'd0;
      zero_r <= 1'b0;
      tgt_r  <= 32'd0;
      link_r <= 32'd0;
      mem_r  <= 4'd0;
      wb_r   <= 2'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= commit_idle_s | commit_shift_s;
      busy_r <= (state_nxt == ST_SHIFT);
      if (commit_idle_s) begin
        res_r  <= alu_s;
        wr_r   <= i_rs2Data;
        zero_r <= zero_s;
        tgt_r  <= target_s;
        link_r <= link_s;
        mem_r  <= i_ctrlMEM;
        wb_r   <= i_ctrlWB;
      end else if (commit_shift_s) begin
        res_r  <= work_nxt;
        wr_r   <= pend_wr_r;
        zero_r <= pend_zero_r;
        tgt_r  <= pend_tgt_r;
        link_r <= pend_link_r;
        mem_r  <= pend_mem_r;
        wb_r   <= pend_wb_r;
      end
    end
  end

  assign o_aluResult    = res_r;
  assign o_wrData       = wr_r;
  assign o_zero         = zero_r;
  assign o_branchTarget = tgt_r;
  assign o_linkAddr     = link_r;
  assign o_ctrlMEM      = mem_r;
  assign o_ctrlWB       = wb_r;
  assign o_busy         = busy_r;
  assign o_done         = done_r;

endmodule

// File: tb/tb_ex_top.sv
// Testbench for ex_top: table vectors, random ops against a reference
// model, and hand sequences for back-to-back issue, ignored start and reset.
module tb_ex_top;

  typedef struct {
    logic [3:0]  op;
    logic        srca, srcb;
    logic [31:0] pc, rs1, rs2, imm;
    logic [2:0]  f3;
    logic        jalr;
    logic [3:0]  cm;
    logic [1:0]  cw;
  } ins_t;

  typedef struct {
    ins_t        in;
    logic [31:0] res, tgt, link;
    logic        zero;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, en, srca, srcb, jalr;
  logic [31:0] pc, rs1, rs2, imm;
  logic [3:0]  op, cmem;
  logic [2:0]  f3;
  logic [1:0]  cwb;

  logic [31:0] r1, wd1, t1, l1, r4, wd4, t4, l4;
  logic        z1, b1, d1, z4, b4, d4;
  logic [3:0]  cm1, cm4;
  logic [1:0]  cw1, cw4;

  int total = 0;
  int passed = 0;

  ex_top #(.SHIFT_STEP(1)) dut1 (
    .i_clk(clk), .i_reset(reset), .en_EX(en), .i_pc(pc), .i_rs1Data(rs1),
    .i_rs2Data(rs2), .i_imm(imm), .i_aluOp(op), .i_aluSrcA(srca), .i_aluSrcB(srcb),
    .i_brFunct3(f3), .i_isJalr(jalr), .i_ctrlMEM(cmem), .i_ctrlWB(cwb),
    .o_aluResult(r1), .o_wrData(wd1), .o_zero(z1), .o_branchTarget(t1),
    .o_linkAddr(l1), .o_ctrlMEM(cm1), .o_ctrlWB(cw1), .o_busy(b1), .o_done(d1));

  ex_top #(.SHIFT_STEP(4)) dut4 (
    .i_clk(clk), .i_reset(reset), .en_EX(en), .i_pc(pc), .i_rs1Data(rs1),
    .i_rs2Data(rs2), .i_imm(imm), .i_aluOp(op), .i_aluSrcA(srca), .i_aluSrcB(srcb),
    .i_brFunct3(f3), .i_isJalr(jalr), .i_ctrlMEM(cmem), .i_ctrlWB(cwb),
    .o_aluResult(r4), .o_wrData(wd4), .o_zero(z4), .o_branchTarget(t4),
    .o_linkAddr(l4), .o_ctrlMEM(cm4), .o_ctrlWB(cw4), .o_busy(b4), .o_done(d4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic ins_t mk(input logic [3:0] o, input logic sa, input logic sb,
                              input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] i, input logic [2:0] f, input logic j);
    ins_t x;
    x.op = o; x.srca = sa; x.srcb = sb; x.pc = p; x.rs1 = a; x.rs2 = b;
    x.imm = i; x.f3 = f; x.jalr = j;
    x.cm = 4'($urandom_range(0, 15)); x.cw = 2'($urandom_range(0, 3));
    return x;
  endfunction

  function automatic ins_t rand_ins();
    ins_t x;
    x = mk(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom, $urandom, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    if ($urandom_range(0, 3) == 0) x.rs2 = x.rs1;
    return x;
  endfunction

  // Reference model: plain arithmetic from the instruction-set rules
  function automatic logic [31:0] ref_res(input ins_t x);
    logic [31:0] a, b, r;
    logic [4:0] sh;
    a = x.srca ? x.pc : x.rs1;
    b = x.srcb ? x.imm : x.rs2;
    sh = b[4:0];
    case (x.op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a << sh;
      4'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: r = (a < b) ? 32'd1 : 32'd0;
      4'd5: r = a ^ b;
      4'd6: r = a >> sh;
      4'd7: r = $signed(a) >>> sh;
      4'd8: r = a | b;
      4'd9: r = a & b;
      4'd10: r = b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic ref_zero(input ins_t x);
    case (x.f3)
      3'b000: return x.rs1 == x.rs2;
      3'b001: return x.rs1 != x.rs2;
      3'b100: return $signed(x.rs1) < $signed(x.rs2);
      3'b101: return $signed(x.rs1) >= $signed(x.rs2);
      3'b110: return x.rs1 < x.rs2;
      3'b111: return x.rs1 >= x.rs2;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_tgt(input ins_t x);
    return x.jalr ? ((x.rs1 + x.imm) & 32'hFFFF_FFFE) : (x.pc + x.imm);
  endfunction

  // Busy cycles before commit: ceil(shamt/step) for a real shift, else 0
  function automatic int ref_lat(input ins_t x, input int step);
    logic [31:0] b;
    int sh;
    b = x.srcb ? x.imm : x.rs2;
    sh = int'(b[4:0]);
    if ((x.op == 4'd2 || x.op == 4'd6 || x.op == 4'd7) && sh != 0) return (sh + step - 1) / step;
    return 0;
  endfunction

  task automatic drive(input ins_t x);
    op = x.op; srca = x.srca; srcb = x.srcb; pc = x.pc; rs1 = x.rs1; rs2 = x.rs2;
    imm = x.imm; f3 = x.f3; jalr = x.jalr; cmem = x.cm; cwb = x.cw;
  endtask

  // Issue one instruction in cycle 0 and observe both DUTs for a bounded window
  task automatic run_op(input ins_t x, input string tag, input logic [31:0] er, input logic ez,
                        input logic [31:0] et, input logic [31:0] el, input int pulse_at);
    int n1, n4, lim, dc1, dc4, bc1, bc4, nd1, nd4, ov;
    logic [31:0] cr, cwd, ct, cl, cr4;
    logic cz;
    logic [3:0] ccm;
    logic [1:0] ccw;
    ins_t junk;
    n1 = ref_lat(x, 1); n4 = ref_lat(x, 4); lim = n1 + 3;
    dc1 = 0; dc4 = 0; bc1 = 0; bc4 = 0; nd1 = 0; nd4 = 0; ov = 0;
    cr = 32'd0; cwd = 32'd0; ct = 32'd0; cl = 32'd0; cr4 = 32'd0; cz = 1'b0; ccm = 4'd0; ccw = 2'd0;
    @(negedge clk); drive(x); en = 1'b1;
    @(negedge clk); en = 1'b0; junk = rand_ins(); drive(junk);
    for (int c = 1; c <= lim; c++) begin
      if (d1) begin
        nd1++;
        if (dc1 == 0) begin
          dc1 = c; cr = r1; cwd = wd1; cz = z1; ct = t1; cl = l1; ccm = cm1; ccw = cw1;
        end
      end
      if (d4) begin
        nd4++;
        if (dc4 == 0) begin dc4 = c; cr4 = r4; end
      end
      if (b1) bc1++;
      if (b4) bc4++;
      if ((b1 && d1) || (b4 && d4)) ov++;
      if (c == pulse_at) begin
        junk = rand_ins(); junk.op = 4'd0; drive(junk); en = 1'b1;
      end else begin
        en = 1'b0;
      end
      if (c < lim) @(negedge clk);
    end
    en = 1'b0;
    chk({tag, ".done_cyc1"}, dc1, n1 + 1);
    chk({tag, ".done_cyc4"}, dc4, n4 + 1);
    chk({tag, ".busy_cnt1"}, bc1, n1);
    chk({tag, ".busy_cnt4"}, bc4, n4);
    chk({tag, ".done_cnt1"}, nd1, 1);
    chk({tag, ".done_cnt4"}, nd4, 1);
    chk({tag, ".busy_done_overlap"}, ov, 0);
    chk({tag, ".result1"}, cr, er);
    chk({tag, ".result4"}, cr4, er);
    chk({tag, ".wrdata"}, cwd, x.rs2);
    chk({tag, ".zero"}, {31'd0, cz}, {31'd0, ez});
    chk({tag, ".target"}, ct, et);
    chk({tag, ".link"}, cl, el);
    chk({tag, ".ctrl_mem"}, {28'd0, ccm}, {28'd0, x.cm});
    chk({tag, ".ctrl_wb"}, {30'd0, ccw}, {30'd0, x.cw});
    chk({tag, ".hold"}, r1, er);
  endtask

  vec_t tbl[10];
  ins_t x;

  initial begin
    tbl[0] = '{in: mk(4'd0, 1'b0, 1'b1, 32'h100, 32'h7FFF_FFFF, 32'h0, 32'h1, 3'b000, 1'b0),
               res: 32'h8000_0000, tgt: 32'h101, link: 32'h104, zero: 1'b0};
    tbl[1] = '{in: mk(4'd3, 1'b0, 1'b0, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h8, 3'b100, 1'b0),
               res: 32'h1, tgt: 32'h208, link: 32'h204, zero: 1'b1};
    tbl[2] = '{in: mk(4'd4, 1'b0, 1'b0, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h8, 3'b110, 1'b0),
               res: 32'h0, tgt: 32'h208, link: 32'h204, zero: 1'b0};
    tbl[3] = '{in: mk(4'd0, 1'b0, 1'b1, 32'h100, 32'h2003, 32'h2003, 32'h4, 3'b000, 1'b1),
               res: 32'h2007, tgt: 32'h2006, link: 32'h104, zero: 1'b1};
    tbl[4] = '{in: mk(4'd0, 1'b0, 1'b1, 32'h100, 32'h2003, 32'h2003, 32'h4, 3'b000, 1'b0),
               res: 32'h2007, tgt: 32'h104, link: 32'h104, zero: 1'b1};
    tbl[5] = '{in: mk(4'd10, 1'b0, 1'b1, 32'h0, 32'h5, 32'h5, 32'hDEAD_BEEF, 3'b101, 1'b0),
               res: 32'hDEAD_BEEF, tgt: 32'hDEAD_BEEF, link: 32'h4, zero: 1'b1};
    tbl[6] = '{in: mk(4'd12, 1'b0, 1'b0, 32'h10, 32'h3, 32'h4, 32'h10, 3'b010, 1'b0),
               res: 32'h0, tgt: 32'h20, link: 32'h14, zero: 1'b0};
    tbl[7] = '{in: mk(4'd1, 1'b1, 1'b0, 32'h10, 32'h0, 32'h20, 32'h0, 3'b001, 1'b0),
               res: 32'hFFFF_FFF0, tgt: 32'h10, link: 32'h14, zero: 1'b1};
    tbl[8] = '{in: mk(4'd7, 1'b0, 1'b0, 32'h0, 32'h8000_0000, 32'd31, 32'h0, 3'b111, 1'b0),
               res: 32'hFFFF_FFFF, tgt: 32'h0, link: 32'h4, zero: 1'b1};
    tbl[9] = '{in: mk(4'd2, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h1234_5678, 32'h20, 32'h0, 3'b110, 1'b0),
               res: 32'h1234_5678, tgt: 32'hFFFF_FFFC, link: 32'h0, zero: 1'b0};

    // Reset state
    reset = 1'b1; en = 1'b0; drive(mk(4'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0));
    repeat (3) @(negedge clk);
    chk("rst.result", r1, 32'h0);
    chk("rst.link", l1, 32'h0);
    chk("rst.ctrl", {26'd0, cm1, cw1}, 32'h0);
    chk("rst.busy_done", {30'd0, b1, d1}, 32'h0);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].in, $sformatf("vec%0d", i), tbl[i].res, tbl[i].zero, tbl[i].tgt, tbl[i].link, 0);
    end

    // Start pulse during an SRL shamt=10 must be ignored
    x = mk(4'd6, 1'b0, 1'b1, 32'h40, 32'hF000_000F, 32'h0, 32'd10, 3'b000, 1'b0);
    run_op(x, "ign", 32'h003C_0000, 1'b0, 32'h4A, 32'h44, 3);

    // Degenerate shift then back-to-back issue in the done cycle
    @(negedge clk);
    drive(mk(4'd2, 1'b0, 1'b0, 32'h0, 32'hA5A5_0001, 32'h20, 32'h0, 3'b000, 1'b0)); en = 1'b1;
    @(negedge clk);
    chk("b2b.done1", {31'd0, d1}, 32'd1);
    chk("b2b.busy1", {31'd0, b1}, 32'd0);
    chk("b2b.result1", r1, 32'hA5A5_0001);
    drive(mk(4'd0, 1'b0, 1'b0, 32'h0, 32'h1, 32'h2, 32'h0, 3'b000, 1'b0)); en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("b2b.done2", {31'd0, d1}, 32'd1);
    chk("b2b.result2", r1, 32'h3);
    chk("b2b.result2_s4", r4, 32'h3);
    @(negedge clk);
    chk("b2b.single_pulse", {31'd0, d1}, 32'd0);
    chk("b2b.hold", r1, 32'h3);

    // Reset in cycle 5 of an SRL shamt=10
    @(negedge clk);
    x = mk(4'd6, 1'b0, 1'b0, 32'h80, 32'hF000_0000, 32'd10, 32'h0, 3'b001, 1'b0);
    x.cm = 4'hF; x.cw = 2'b11;
    drive(x); en = 1'b1;
    @(negedge clk); en = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid.result1", r1, 32'h0);
    chk("rstmid.result4", r4, 32'h0);
    chk("rstmid.misc1", {wd1 | t1 | l1}, 32'h0);
    chk("rstmid.flags1", {24'd0, z1, b1, d1, cm1, cw1[0]}, 32'h0);
    chk("rstmid.flags4", {24'd0, z4, b4, d4, cm4, cw4[0]}, 32'h0);
    begin
      int late = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (d1 || b1) late++;
      end
      chk("rstmid.no_done", late, 0);
    end

    // Random instructions against the reference model
    for (int i = 0; i < 40; i++) begin
      x = rand_ins();
      if (i % 4 == 0) x.op = 4'(6 + (i % 3));
      run_op(x, $sformatf("rnd%0d", i), ref_res(x), ref_zero(x), ref_tgt(x), x.pc + 32'd4, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ex_top.md
# ex_top

Execute stage of the multicycle RV32I core; sits directly upstream of the memory stage and produces its ALU result/address, store data, branch-condition flag, branch target and pass-through control. Add/sub/logic/compare/branch evaluation complete in one cycle. Shifts run on an iterative shifter that retires `SHIFT_STEP` bit positions per cycle and reports progress to the stage sequencer through `o_busy`/`o_done`. All outputs are registered and hold until the next instruction commits.

## Interface
- `SHIFT_STEP`, default 1: bit positions shifted per busy cycle. Legal values are 1, 2, 4, 8.
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `en_EX` in 1: start pulse for the current instruction. Accepted only in IDLE.
- `i_pc` in 32: PC of the instruction.
- `i_rs1Data`, `i_rs2Data` in 32 each: register operands.
- `i_imm` in 32: sign-extended immediate.
- `i_aluOp` in 4: operation code. 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB. Codes 11–15 produce result 0.
- `i_aluSrcA` in 1: A operand select. 0 = rs1, 1 = PC.
- `i_aluSrcB` in 1: B operand select. 0 = rs2, 1 = imm.
- `i_brFunct3` in 3: branch compare type, always rs1 vs rs2. 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. 010 and 011 give false.
- `i_isJalr` in 1: selects the JALR target form.
- `i_ctrlMEM` in mem_ctrl_t: memory-stage control, passed through.
- `i_ctrlWB` in wb_ctrl_t: write-back control, passed through.
- `o_aluResult` out 32: ALU result; used as the memory address.
- `o_wrData` out 32: store data (rs2 as captured).
- `o_zero` out 1: branch condition true.
- `o_branchTarget` out 32: branch/jump target.
- `o_linkAddr` out 32: PC+4.
- `o_ctrlMEM`, `o_ctrlWB` out: registered control pass-through.
- `o_busy` out 1: a shift is in progress.
- `o_done` out 1: one-cycle pulse when outputs commit.

## Operation
- **Operand selection.** A = `i_aluSrcA` ? `i_pc` : `i_rs1Data`; B = `i_aluSrcB` ? `i_imm` : `i_rs2Data`.
- **Arithmetic.** All 32-bit, wrap-around; no overflow or carry is exported.
- **Compares.** SLT is a signed compare, SLTU unsigned; result is 0 or 1, zero-extended.
- **Shifts.** Shift amount is B[4:0]; upper bits of B are ignored. SRA fills with A[31].
- **Target.** `o_branchTarget` = `i_isJalr` ? ((rs1+imm) & ~1) : (pc+imm).
- **Link address.** `o_linkAddr` = pc+4, modulo 2^32.
- **Branch flag.** `o_zero` is computed from rs1/rs2 per `i_brFunct3`, independent of `i_aluOp`. The memory stage gates it with Branch.
- **Input capture.** On accepting `en_EX`, all inputs needed later are captured internally: rs2, control, the branch flag, target and link. The upstream stage may change its inputs the following cycle.
- **State machine:**
  - IDLE → IDLE on `en_EX` with a non-shift op, or a shift with shamt = 0. All outputs commit on that edge.
  - IDLE → SHIFT on `en_EX` with a shift op and shamt ≠ 0. Load work = A, rem = shamt.
  - SHIFT, each cycle: shift work by min(`SHIFT_STEP`, rem) and decrement rem by the same amount. When the step consumes the final rem, commit all outputs and go to IDLE.
- **`en_EX` while in SHIFT** is ignored. No queueing, no effect on the shift in progress.
- **Reset** (any state, including mid-shift) clears the outputs below and forces IDLE. The in-flight instruction is discarded.
  - `o_aluResult`, `o_wrData`, `o_zero`, `o_branchTarget`, `o_linkAddr`, `o_busy`, `o_done` = 0.
  - `o_ctrlMEM`, `o_ctrlWB` = all-zero (no Branch, Jump, MemRead, MemWrite or RegWrite).

## Timing
- **Cycle numbering.** `en_EX` is sampled in cycle 0.
- **Non-shift latency.** Outputs are valid and `o_done` = 1 in cycle 1. Latency 1.
- **Shift latency.** Let N = ceil(shamt / `SHIFT_STEP`).
  - `o_busy` = 1 in cycles 1..N.
  - Outputs are valid and `o_done` = 1 in cycle N+1.
  - Maximum N is 31 (`SHIFT_STEP` = 1, shamt = 31), giving latency 32.
- **`o_done` width.** Exactly one cycle per accepted instruction.
- **`o_busy` and `o_done` together.** Never high in the same cycle.
- **New instruction in the `o_done` cycle.** `en_EX` may be asserted in the same cycle `o_done` is high (state is IDLE) and is accepted.
- **Output hold.** All outputs keep their values between commits. They change only on a commit edge or on reset.

## Test plan
- **ADD with immediate.** rs1=0x7FFFFFFF, imm=1, aluSrcB=1, ADD → cycle 1: `o_aluResult`=0x80000000, `o_done`=1, `o_busy`=0.
- **Signed vs unsigned compare and branch flag.** rs1=0xFFFFFFFF, rs2=1.
  - SLT → result 1; SLTU → result 0.
  - brFunct3=100 → `o_zero`=1; brFunct3=110 → `o_zero`=0.
- **Arithmetic right shift.** SRA, A=0x80000000, B=31, `SHIFT_STEP`=1 → `o_busy` in cycles 1–31; cycle 32: result 0xFFFFFFFF and `o_done`=1. Repeat with `SHIFT_STEP`=4 → done in cycle 9.
- **Degenerate shift with back-to-back issue.** SLL with B=0x20 (shamt 0) → cycle 1: result = A, `o_busy` never asserted. Assert `en_EX` again in cycle 1 → accepted; second result appears in cycle 2.
- **JALR target and link.** pc=0x100, rs1=0x2003, imm=4, `i_isJalr`=1 → `o_branchTarget`=0x2006, `o_linkAddr`=0x104. With `i_isJalr`=0 → `o_branchTarget`=0x104.
- **Disturbances during a shift.** During an SRL with shamt=10, pulse `en_EX` in cycle 3 → ignored, single `o_done` in cycle 11. Separately, assert `i_reset` in cycle 5 → cycle 6: all outputs 0, IDLE, no `o_done`.
